decode_stage: RTL and testbench

Pipelined, parametrised successor to the single-cycle MIPS decoder. It accepts one 32-bit instruction per cycle from fetch over a valid/ready handshake and decodes it into the existing control encoding. The decoded word is held in one output pipeline register for execute. It also detects load-use hazards and inserts one bubble for each, honours a flush from branch/jump resolution, flags illegal opcodes, and keeps a saturating stall counter.

---
 rtl/decode_pkg.sv | 78 +++++++
 rtl/decode_logic.sv | 100 ++++++++++
 rtl/decode_stage.sv | 127 ++++++++++++
 tb/tb_decode_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared MIPS decode constants, control encodings and the decoded control word.
// Used by the pipelined decode stage as well as the legacy single-cycle decoder.
package decode_pkg;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpXori  = 6'h0E;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {
        AluAdd  = 3'd0,
        AluSub  = 3'd1,
        AluXor  = 3'd2,
        AluSlt  = 3'd3,
        AluAnd  = 3'd4,
        AluNand = 3'd5,
        AluNor  = 3'd6,
        AluOr   = 3'd7
    } aluOpT;

    typedef enum logic [1:0] {
        DwAlu = 2'd0,
        DwPc4 = 2'd1,
        DwMem = 2'd2
    } dwSelT;

    typedef enum logic [1:0] {
        JReg    = 2'd0,
        JTarget = 2'd1,
        JPc4    = 2'd2
    } jSelT;

    typedef enum logic [1:0] {
        PcNone = 2'd0,
        PcBeq  = 2'd1,
        PcBne  = 2'd2
    } pcSelT;

    typedef struct packed {
        logic        immSel;
        logic        memWrEn;
        logic        regWrEn;
        dwSelT       dwSel;
        jSelT        jSel;
        pcSelT       pcSel;
        logic [4:0]  aa;
        logic [4:0]  ab;
        logic [4:0]  aw;
        aluOpT       aluOp;
        logic [15:0] imm;
        logic [25:0] jumpAddr;
        logic        illegal;
    } ctrlT;

    // Control word that changes no architectural state and falls through to PC+4.
    function automatic ctrlT nopCtrl();
        ctrlT c;
        c      = '0;
        c.jSel = JPc4;
        return c;
    endfunction

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic readsRt(input logic [5:0] op);
        return (op == OpRtype) || (op == OpSw) || (op == OpBeq) || (op == OpBne);
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Purely combinational MIPS instruction to control-word mapping.
// Unsupported opcodes/functs produce a NOP control word with the illegal flag set.
module decode_logic
    import decode_pkg::*;
#(
    parameter logic [4:0] JAL_REG = 5'd31
) (
    input  logic [31:0] instr,
    output ctrlT        ctrl
);

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unusedShamt;

    assign op          = instr[31:26];
    assign rs          = instr[25:21];
    assign rt          = instr[20:16];
    assign rd          = instr[15:11];
    assign funct       = instr[5:0];
    assign unusedShamt = ^instr[10:6];

    always_comb begin
        ctrl          = nopCtrl();
        ctrl.aa       = rs;
        ctrl.ab       = rt;
        ctrl.aw       = rt;
        ctrl.imm      = instr[15:0];
        ctrl.jumpAddr = instr[25:0];

        case (op)
            OpRtype: begin
                case (funct)
                    FnAdd: begin
                        ctrl.regWrEn = 1'b1;
                        ctrl.aw      = rd;
                        ctrl.aluOp   = AluAdd;
                    end
                    FnSub: begin
                        ctrl.regWrEn = 1'b1;
                        ctrl.aw      = rd;
                        ctrl.aluOp   = AluSub;
                    end
                    FnSlt: begin
                        ctrl.regWrEn = 1'b1;
                        ctrl.aw      = rd;
                        ctrl.aluOp   = AluSlt;
                    end
                    FnJr: begin
                        ctrl.jSel = JReg;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OpLw: begin
                ctrl.immSel  = 1'b1;
                ctrl.aluOp   = AluAdd;
                ctrl.dwSel   = DwMem;
                ctrl.regWrEn = 1'b1;
            end
            OpSw: begin
                ctrl.immSel  = 1'b1;
                ctrl.aluOp   = AluAdd;
                ctrl.memWrEn = 1'b1;
            end
            OpJ: begin
                ctrl.jSel = JTarget;
            end
            OpJal: begin
                ctrl.jSel    = JTarget;
                ctrl.regWrEn = 1'b1;
                ctrl.dwSel   = DwPc4;
                ctrl.aw      = JAL_REG;
            end
            OpBeq: begin
                ctrl.aluOp = AluSub;
                ctrl.pcSel = PcBeq;
            end
            OpBne: begin
                ctrl.aluOp = AluSub;
                ctrl.pcSel = PcBne;
            end
            OpXori: begin
                ctrl.immSel  = 1'b1;
                ctrl.aluOp   = AluXor;
                ctrl.regWrEn = 1'b1;
            end
            OpAddi: begin
                ctrl.immSel  = 1'b1;
                ctrl.aluOp   = AluAdd;
                ctrl.regWrEn = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode stage: valid/ready intake, one registered control word for execute,
// load-use bubble insertion, flush, and a saturating stall counter.
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter bit          HAZARD_EN = 1'b1,
    parameter logic [4:0]  JAL_REG   = 5'd31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             immSel,
    output logic             memWrEn,
    output logic             regWrEn,
    output logic [1:0]       DwSel,
    output logic [1:0]       jSel,
    output logic [1:0]       pcSel,
    output logic [4:0]       Aa,
    output logic [4:0]       Ab,
    output logic [4:0]       Aw,
    output logic [2:0]       aluOp,
    output logic [15:0]      imm,
    output logic [25:0]      jumpAddr,
    output logic             illegal,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        StRun,
        StBubble
    } stateT;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    ctrlT             decoded;
    ctrlT             ctrlQ;
    logic             validQ;
    stateT            stQ;
    logic [CNT_W-1:0] stallQ;
    logic [5:0]       opIn;
    logic [4:0]       rsIn;
    logic [4:0]       rtIn;
    logic             heldLoad;
    logic             hazard;
    logic             accept;

    decode_logic #(
        .JAL_REG(JAL_REG)
    ) uDecodeLogic (
        .instr(in_instr),
        .ctrl (decoded)
    );

    assign opIn = in_instr[31:26];
    assign rsIn = in_instr[25:21];
    assign rtIn = in_instr[20:16];

    // Only LW selects memory write-back, so dwSel identifies a held load.
    assign heldLoad = validQ && (ctrlQ.dwSel == DwMem) && (ctrlQ.aw != 5'd0);

    // The bubble cycle has already separated the load, so no re-check there.
    assign hazard = HAZARD_EN && (stQ == StRun) && in_valid && heldLoad &&
                    ((ctrlQ.aw == rsIn) || ((ctrlQ.aw == rtIn) && readsRt(opIn)));

    assign in_ready = !flush && !hazard && (!validQ || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            validQ <= 1'b0;
            ctrlQ  <= nopCtrl();
            stQ    <= StRun;
            stallQ <= '0;
        end else if (flush) begin
            validQ <= 1'b0;
            stQ    <= StRun;
        end else begin
            case (stQ)
                StRun: begin
                    if (hazard && out_ready) begin
                        validQ <= 1'b0;
                        stQ    <= StBubble;
                        if (stallQ != '1) begin
                            stallQ <= stallQ + CntOne;
                        end
                    end else if (accept) begin
                        validQ <= 1'b1;
                        ctrlQ  <= decoded;
                    end else if (out_ready) begin
                        validQ <= 1'b0;
                    end
                end
                StBubble: begin
                    stQ <= StRun;
                    if (accept) begin
                        validQ <= 1'b1;
                        ctrlQ  <= decoded;
                    end
                end
                default: stQ <= StRun;
            endcase
        end
    end

    assign out_valid = validQ;
    assign immSel    = ctrlQ.immSel;
    assign memWrEn   = ctrlQ.memWrEn;
    assign regWrEn   = ctrlQ.regWrEn;
    assign DwSel     = ctrlQ.dwSel;
    assign jSel      = ctrlQ.jSel;
    assign pcSel     = ctrlQ.pcSel;
    assign Aa        = ctrlQ.aa;
    assign Ab        = ctrlQ.ab;
    assign Aw        = ctrlQ.aw;
    assign aluOp     = ctrlQ.aluOp;
    assign imm       = ctrlQ.imm;
    assign jumpAddr  = ctrlQ.jumpAddr;
    assign illegal   = ctrlQ.illegal;
    assign stall_cnt = stallQ;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default instance plus HAZARD_EN=0 and CNT_W=2 variants
// sharing the same input stimulus.
module tb_decode_stage;

    localparam logic [31:0] InstrLw   = 32'h8D55CCCC; // lw   r21, 0xCCCC(r10)
    localparam logic [31:0] InstrAdd  = 32'h00351820; // add  r3, r1, r21
    localparam logic [31:0] InstrJal  = 32'h0CCCCCCC; // jal  0x0CCCCCC
    localparam logic [31:0] InstrBne  = 32'h14430010; // bne  r2, r3, 0x10
    localparam logic [31:0] InstrXori = 32'h388500FF; // xori r5, r4, 0xFF
    localparam logic [31:0] InstrBadOp = 32'hFC000000;
    localparam logic [31:0] InstrBadFn = 32'h0000003F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    logic        in_ready, out_valid, immSel, memWrEn, regWrEn, illegal;
    logic [1:0]  DwSel, jSel, pcSel;
    logic [4:0]  Aa, Ab, Aw;
    logic [2:0]  aluOp;
    logic [15:0] imm;
    logic [25:0] jumpAddr;
    logic [15:0] stall_cnt;

    logic        nhReady, nhValid, nhImmSel, nhMemWrEn, nhRegWrEn, nhIllegal;
    logic [1:0]  nhDwSel, nhJSel, nhPcSel;
    logic [4:0]  nhAa, nhAb, nhAw;
    logic [2:0]  nhAluOp;
    logic [15:0] nhImm;
    logic [25:0] nhJumpAddr;
    logic [15:0] nhStall;

    logic        stReady, stValid, stImmSel, stMemWrEn, stRegWrEn, stIllegal;
    logic [1:0]  stDwSel, stJSel, stPcSel;
    logic [4:0]  stAa, stAb, stAw;
    logic [2:0]  stAluOp;
    logic [15:0] stImm;
    logic [25:0] stJumpAddr;
    logic [1:0]  stStall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .immSel(immSel), .memWrEn(memWrEn), .regWrEn(regWrEn), .DwSel(DwSel), .jSel(jSel),
        .pcSel(pcSel), .Aa(Aa), .Ab(Ab), .Aw(Aw), .aluOp(aluOp), .imm(imm),
        .jumpAddr(jumpAddr), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    decode_stage #(.HAZARD_EN(1'b0)) dutNoHaz (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(nhReady),
        .in_instr(in_instr), .flush(flush), .out_valid(nhValid), .out_ready(out_ready),
        .immSel(nhImmSel), .memWrEn(nhMemWrEn), .regWrEn(nhRegWrEn), .DwSel(nhDwSel),
        .jSel(nhJSel), .pcSel(nhPcSel), .Aa(nhAa), .Ab(nhAb), .Aw(nhAw), .aluOp(nhAluOp),
        .imm(nhImm), .jumpAddr(nhJumpAddr), .illegal(nhIllegal), .stall_cnt(nhStall)
    );

    decode_stage #(.CNT_W(2)) dutSat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(stReady),
        .in_instr(in_instr), .flush(flush), .out_valid(stValid), .out_ready(out_ready),
        .immSel(stImmSel), .memWrEn(stMemWrEn), .regWrEn(stRegWrEn), .DwSel(stDwSel),
        .jSel(stJSel), .pcSel(stPcSel), .Aa(stAa), .Ab(stAb), .Aw(stAw), .aluOp(stAluOp),
        .imm(stImm), .jumpAddr(stJumpAddr), .illegal(stIllegal), .stall_cnt(stStall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_instr = '0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got=%0h want=0", illegal); end
        checks++; if (jSel !== 2'd2) begin errors++; $display("FAIL rst_jsel got=%0h want=2", jSel); end
        checks++; if ({regWrEn, memWrEn, DwSel, pcSel} !== 6'd0) begin errors++; $display("FAIL rst_ctrl got=%0h want=0", {regWrEn, memWrEn, DwSel, pcSel}); end
        checks++; if ({Aa, Ab, Aw, imm, jumpAddr} !== 57'd0) begin errors++; $display("FAIL rst_fields got=%0h want=0", {Aa, Ab, Aw, imm, jumpAddr}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_stall got=%0h want=0", stall_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_lw;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrLw;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_ready got=%0h want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lw_valid got=%0h want=1", out_valid); end
        checks++; if (Aa !== 5'h0A) begin errors++; $display("FAIL lw_aa got=%0h want=0a", Aa); end
        checks++; if (Ab !== 5'h15) begin errors++; $display("FAIL lw_ab got=%0h want=15", Ab); end
        checks++; if (Aw !== 5'h15) begin errors++; $display("FAIL lw_aw got=%0h want=15", Aw); end
        checks++; if (DwSel !== 2'd2) begin errors++; $display("FAIL lw_dwsel got=%0h want=2", DwSel); end
        checks++; if ({regWrEn, memWrEn, immSel} !== 3'b101) begin errors++; $display("FAIL lw_en got=%0b want=101", {regWrEn, memWrEn, immSel}); end
        checks++; if (aluOp !== 3'd0) begin errors++; $display("FAIL lw_aluop got=%0h want=0", aluOp); end
        checks++; if (jSel !== 2'd2) begin errors++; $display("FAIL lw_jsel got=%0h want=2", jSel); end
        checks++; if (imm !== 16'hCCCC) begin errors++; $display("FAIL lw_imm got=%0h want=cccc", imm); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lw_drain got=%0h want=0", out_valid); end
    endtask

    task automatic test_hazard;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrLw;
        tick();
        in_instr = InstrAdd;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL haz_ready got=%0h want=0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL haz_bubble got=%0h want=0", out_valid); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL haz_stall got=%0h want=1", stall_cnt); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL haz_ready_bubble got=%0h want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL haz_add_valid got=%0h want=1", out_valid); end
        checks++; if (Aw !== 5'd3) begin errors++; $display("FAIL haz_add_aw got=%0h want=3", Aw); end
        checks++; if ({regWrEn, immSel, DwSel} !== 4'b1000) begin errors++; $display("FAIL haz_add_ctrl got=%0b want=1000", {regWrEn, immSel, DwSel}); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL haz_stall_hold got=%0h want=1", stall_cnt); end
        tick();
    endtask

    task automatic test_no_hazard;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrLw;
        tick();
        checks++; if ({nhValid, nhAw} !== {1'b1, 5'h15}) begin errors++; $display("FAIL nohaz_lw got=%0h want=35", {nhValid, nhAw}); end
        in_instr = InstrAdd;
        #1;
        checks++; if (nhReady !== 1'b1) begin errors++; $display("FAIL nohaz_ready got=%0h want=1", nhReady); end
        tick();
        in_valid = 1'b0;
        checks++; if ({nhValid, nhAw} !== {1'b1, 5'd3}) begin errors++; $display("FAIL nohaz_add got=%0h want=23", {nhValid, nhAw}); end
        checks++; if (nhStall !== 16'd0) begin errors++; $display("FAIL nohaz_stall got=%0h want=0", nhStall); end
    endtask

    task automatic test_back_to_back;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrJal;
        tick();
        in_instr = InstrBne;
        checks++; if (Aw !== 5'd31) begin errors++; $display("FAIL jal_aw got=%0h want=1f", Aw); end
        checks++; if ({DwSel, jSel, pcSel} !== 6'b01_01_00) begin errors++; $display("FAIL jal_sel got=%0b want=010100", {DwSel, jSel, pcSel}); end
        checks++; if ({regWrEn, memWrEn} !== 2'b10) begin errors++; $display("FAIL jal_en got=%0b want=10", {regWrEn, memWrEn}); end
        checks++; if (jumpAddr !== 26'h0CCCCCC) begin errors++; $display("FAIL jal_target got=%0h want=0cccccc", jumpAddr); end
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0h want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bne_valid got=%0h want=1", out_valid); end
        checks++; if ({pcSel, aluOp, immSel} !== 6'b10_001_0) begin errors++; $display("FAIL bne_ctrl got=%0b want=100010", {pcSel, aluOp, immSel}); end
        checks++; if ({regWrEn, jSel} !== 3'b0_10) begin errors++; $display("FAIL bne_wr got=%0b want=010", {regWrEn, jSel}); end
        checks++; if ({Aa, Ab} !== {5'd2, 5'd3}) begin errors++; $display("FAIL bne_regs got=%0h want=43", {Aa, Ab}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0h want=0", out_valid); end
    endtask

    task automatic test_hold;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrLw;
        tick();
        out_ready = 1'b0; in_instr = InstrXori;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d] got=%0h want=0", i, in_ready); end
            checks++; if ({out_valid, Aw, imm} !== {1'b1, 5'h15, 16'hCCCC}) begin errors++; $display("FAIL hold_out[%0d] got=%0h want=35cccc", i, {out_valid, Aw, imm}); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release got=%0h want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if ({out_valid, Aw, imm} !== {1'b1, 5'd5, 16'h00FF}) begin errors++; $display("FAIL xori_out got=%0h want=2500ff", {out_valid, Aw, imm}); end
        checks++; if ({aluOp, immSel, regWrEn} !== 5'b010_1_1) begin errors++; $display("FAIL xori_ctrl got=%0b want=01011", {aluOp, immSel, regWrEn}); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_nodup got=%0h want=0", out_valid); end
    endtask

    task automatic test_flush;
        reset_dut();
        in_valid = 1'b1; in_instr = InstrLw;
        tick();
        out_ready = 1'b0; in_instr = InstrAdd;
        tick();
        checks++; if ({out_valid, Aw} !== {1'b1, 5'h15}) begin errors++; $display("FAIL flush_pending got=%0h want=35", {out_valid, Aw}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_pending_stall got=%0h want=0", stall_cnt); end
        flush = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%0h want=0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0h want=0", out_valid); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL flush_stall got=%0h want=0", stall_cnt); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept got=%0h want=0", out_valid); end
        out_ready = 1'b1;
    endtask

    task automatic test_saturate;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = InstrLw;
            tick();
            in_instr = InstrAdd;
            tick();
            tick();
            in_valid = 1'b0;
            tick();
            checks++; if (stall_cnt !== 16'(i + 1)) begin errors++; $display("FAIL sat_wide[%0d] got=%0d want=%0d", i, stall_cnt, i + 1); end
            checks++; if (stStall !== ((i < 3) ? 2'(i + 1) : 2'd3)) begin errors++; $display("FAIL sat_narrow[%0d] got=%0d want=%0d", i, stStall, (i < 3) ? i + 1 : 3); end
        end
    endtask

    task automatic test_illegal_reset;
        in_valid = 1'b1; in_instr = InstrBadOp;
        tick();
        in_instr = InstrBadFn;
        checks++; if ({out_valid, illegal} !== 2'b11) begin errors++; $display("FAIL ill_op got=%0b want=11", {out_valid, illegal}); end
        checks++; if ({regWrEn, memWrEn, jSel, pcSel} !== 6'b00_10_00) begin errors++; $display("FAIL ill_nop got=%0b want=001000", {regWrEn, memWrEn, jSel, pcSel}); end
        tick();
        checks++; if ({out_valid, illegal, regWrEn} !== 3'b110) begin errors++; $display("FAIL ill_fn got=%0b want=110", {out_valid, illegal, regWrEn}); end
        in_instr = InstrLw; rst_n = 1'b0;
        tick();
        checks++; if ({out_valid, illegal} !== 2'b00) begin errors++; $display("FAIL midrst_valid got=%0b want=00", {out_valid, illegal}); end
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL midrst_stall got=%0h want=0", stall_cnt); end
        checks++; if ({Aa, Aw, jumpAddr} !== 36'd0) begin errors++; $display("FAIL midrst_fields got=%0h want=0", {Aa, Aw, jumpAddr}); end
        checks++; if ({jSel, DwSel, regWrEn} !== 5'b10_00_0) begin errors++; $display("FAIL midrst_ctrl got=%0b want=10000", {jSel, DwSel, regWrEn}); end
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_hazard();
        test_no_hazard();
        test_back_to_back();
        test_hold();
        test_flush();
        test_saturate();
        test_illegal_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
